// File: rtl/coef_stream_reader_pkg.sv
// ntt_pkg: shared types, default widths and helper functions for the NTT
// coefficient datapath.
//   state_t   : read-out engine states (IDLE, READ, DRAIN, DONE)
//   lane_ext  : widen a coefficient into a lane slot, zero-padded or
//               sign-extended
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned COEF_W_DEF = 23;
    localparam int unsigned SLOT_W_DEF = 32;

    // Working width of lane_ext; callers cast the result down to their slot width.
    localparam int unsigned EXT_W = 64;

    // Keeps the low coef_w bits of coef. Every bit above them becomes the
    // coefficient's top bit when signed_mode is set, and 0 otherwise.
    function automatic logic [EXT_W-1:0] lane_ext(
        input logic [EXT_W-1:0] coef,
        input int unsigned      coef_w,
        input logic             signed_mode
    );
        logic [EXT_W-1:0] mask;
        logic             sign;
        mask = (coef_w >= EXT_W) ? '1 : ((EXT_W'(1) << coef_w) - EXT_W'(1));
        sign = |(coef & (EXT_W'(1) << (coef_w - 1)));
        return (coef & mask) | ({EXT_W{signed_mode & sign}} & ~mask);
    endfunction

endpackage

// File: rtl/coef_stream_reader_stream_fifo.sv
// stream_fifo: synchronous FIFO with asynchronous active-low reset.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_data : write strobe and data
//   i_pop          : read strobe; o_data advances after the pop
//   o_data         : head entry, 0 while the FIFO is empty
//   o_count        : occupancy
//   o_full/o_empty : occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_rd;
    logic             w_wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rd = i_pop & (r_count != '0);
    assign w_wr = i_push & ((r_count != CNT_W'(DEPTH)) | w_rd);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
        end
    end

    // The output is forced to 0 while empty so that nothing stale appears on
    // the bus after a reset or after a drain.
    assign o_data  = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/coef_stream_reader.sv
// coef_stream_reader: reads N_COEF coefficients from a dual-port BRAM, two
// per cycle, and streams them as two-lane AXI4-Stream beats.
//   clk, rst_n                : clock, async active-low reset
//   start, cfg_signed         : run request; cfg_signed is latched on accept
//   busy, done                : run in progress / one-cycle completion pulse
//   m_axis_*                  : AXI4-Stream master, lane 0 in the low slot
//   coef_en*/we*/addr*/dout*  : BRAM read ports, RD_LAT cycles of read latency
// An output FIFO of RD_LAT+2 entries absorbs back-pressure. Reads are issued
// only while the FIFO has room for every read still in flight.
module coef_stream_reader
    import ntt_pkg::*;
#(
    parameter int unsigned COEF_W = COEF_W_DEF,
    parameter int unsigned SLOT_W = SLOT_W_DEF,
    parameter int unsigned N_COEF = 256,
    parameter int unsigned ADDR_W = $clog2(N_COEF),
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cfg_signed,
    output logic                busy,
    output logic                done,
    output logic [2*SLOT_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                coef_ena,
    output logic                coef_enb,
    output logic                coef_wea,
    output logic                coef_web,
    output logic [ADDR_W-1:0]   coef_addra,
    output logic [ADDR_W-1:0]   coef_addrb,
    input  logic [COEF_W-1:0]   coef_douta,
    input  logic [COEF_W-1:0]   coef_doutb
);

    localparam int unsigned FIFO_DEPTH = RD_LAT + 2;
    localparam int unsigned FIFO_W     = 2 * SLOT_W + 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CR_W       = CNT_W + 1;
    localparam int unsigned K_W        = ADDR_W - 1;
    localparam logic [K_W-1:0] K_LAST  = K_W'(N_COEF / 2 - 1);

    state_t             r_state;
    logic [K_W-1:0]     r_k;
    logic               r_signed;
    logic               r_busy;
    logic               r_done;
    logic               r_ena;
    logic               r_ena_last;
    logic [ADDR_W-1:0]  r_addra;
    logic [ADDR_W-1:0]  r_addrb;
    logic [RD_LAT-1:0]  r_vld;
    logic [RD_LAT-1:0]  r_lst;
    logic [CR_W-1:0]    r_pend;

    logic [SLOT_W-1:0]  w_lane_a;
    logic [SLOT_W-1:0]  w_lane_b;
    logic [FIFO_W-1:0]  w_fifo_in;
    logic [FIFO_W-1:0]  w_fifo_out;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_last_out;
    logic [CR_W-1:0]    w_used;
    logic               w_can_issue;

    // A read issued while r_ena is high returns RD_LAT cycles later.
    // r_vld/r_lst track that slot; r_pend counts reads that were issued in
    // earlier cycles and have not been pushed yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_lst  <= '0;
            r_pend <= '0;
        end else begin
            r_vld  <= (r_vld << 1) | RD_LAT'(r_ena);
            r_lst  <= (r_lst << 1) | RD_LAT'(r_ena & r_ena_last);
            r_pend <= r_pend + CR_W'(r_ena) - CR_W'(w_push);
        end
    end

    assign w_push   = r_vld[RD_LAT-1];
    assign w_lane_a = SLOT_W'(lane_ext(EXT_W'(coef_douta), COEF_W, r_signed));
    assign w_lane_b = SLOT_W'(lane_ext(EXT_W'(coef_doutb), COEF_W, r_signed));
    assign w_fifo_in = {r_lst[RD_LAT-1], w_lane_b, w_lane_a};

    stream_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign m_axis_tvalid = ~w_fifo_empty;
    assign m_axis_tdata  = w_fifo_out[2*SLOT_W-1:0];
    assign w_last_out    = w_fifo_out[2*SLOT_W];
    assign m_axis_tlast  = w_last_out;
    assign w_pop         = m_axis_tvalid & m_axis_tready;

    // Decide now whether a read goes out next cycle. Entries that will be in
    // the FIFO once that read returns: current occupancy, minus this cycle's
    // pop, plus every read still outstanding (including the one on the BRAM
    // port now). Later pops only free space, so the estimate is safe.
    assign w_used = CR_W'(w_fifo_count) - CR_W'(w_pop) + r_pend + CR_W'(r_ena);
    assign w_can_issue = (w_fifo_full & ~w_pop) ? 1'b0 : (w_used < CR_W'(FIFO_DEPTH));

    // The first pair is issued at the moment start is accepted, so that its
    // enable appears in cycle 1. From then on r_k is the next pair to issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_signed   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ena      <= 1'b0;
            r_ena_last <= 1'b0;
            r_addra    <= '0;
            r_addrb    <= '0;
        end else begin
            r_ena      <= 1'b0;
            r_ena_last <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_signed <= cfg_signed;
                        r_busy   <= 1'b1;
                        r_ena    <= 1'b1;
                        r_addra  <= '0;
                        r_addrb  <= ADDR_W'(1);
                        r_k      <= K_W'(1);
                        r_state  <= READ;
                    end
                end
                READ: begin
                    if (w_can_issue) begin
                        r_ena   <= 1'b1;
                        r_addra <= {r_k, 1'b0};
                        r_addrb <= {r_k, 1'b1};
                        if (r_k == K_LAST) begin
                            r_ena_last <= 1'b1;
                            r_state    <= DRAIN;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The tlast handshake implies that every read has returned
                    // and every earlier beat has left the FIFO.
                    if (w_pop && w_last_out) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign coef_ena   = r_ena;
    assign coef_enb   = r_ena;
    assign coef_wea   = 1'b0;
    assign coef_web   = 1'b0;
    assign coef_addra = r_addra;
    assign coef_addrb = r_addrb;

endmodule

// File: tb/tb_coef_stream_reader.sv
// Directed bench for coef_stream_reader. u_dut uses the default parameters
// (N_COEF = 256, RD_LAT = 1) and u_dut2 uses RD_LAT = 2 with N_COEF = 4.
// Cycle 0 is the cycle in which start is sampled high.
module tb_coef_stream_reader;

    localparam int DEPTH1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start = 1'b0, cfg_signed = 1'b0, tready = 1'b1;
    logic        busy, done, tvalid, tlast, ena, enb, wea, web;
    logic [63:0] tdata;
    logic [7:0]  addra, addrb;
    logic [22:0] douta, doutb;

    logic        start2 = 1'b0, cfg_signed2 = 1'b0, tready2 = 1'b1;
    logic        busy2, done2, tvalid2, tlast2, ena2, enb2, wea2, web2;
    logic [63:0] tdata2;
    logic [1:0]  addra2, addrb2;
    logic [22:0] douta2, doutb2, s2a, s2b;

    logic [22:0] mem1 [256];
    logic [22:0] mem2 [4];

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    coef_stream_reader u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_signed(cfg_signed),
        .busy(busy), .done(done), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .coef_ena(ena), .coef_enb(enb),
        .coef_wea(wea), .coef_web(web), .coef_addra(addra), .coef_addrb(addrb),
        .coef_douta(douta), .coef_doutb(doutb)
    );

    coef_stream_reader #(.N_COEF(4), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cfg_signed(cfg_signed2),
        .busy(busy2), .done(done2), .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2),
        .m_axis_tready(tready2), .m_axis_tlast(tlast2), .coef_ena(ena2), .coef_enb(enb2),
        .coef_wea(wea2), .coef_web(web2), .coef_addra(addra2), .coef_addrb(addrb2),
        .coef_douta(douta2), .coef_doutb(doutb2)
    );

    // BRAM models: one register stage for u_dut, two for u_dut2.
    always @(posedge clk) begin
        if (ena) douta <= mem1[addra];
        if (enb) doutb <= mem1[addrb];
        if (ena2) s2a <= mem2[addra2];
        if (enb2) s2b <= mem2[addrb2];
        douta2 <= s2a;
        doutb2 <= s2b;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_lane(input logic [22:0] c, input bit sgn);
        return (sgn && c[22]) ? {9'h1FF, c} : {9'h000, c};
    endfunction

    // Runs one full stream on u_dut. extra_start pulses start in that cycle;
    // start_on_done pulses start in the cycle where done is seen.
    task automatic run_stream(input bit rnd, input bit sgn, input int extra_start,
                              input bit start_on_done, output int beats,
                              output int done_cyc, output int first_v,
                              output logic [63:0] beat0);
        int          issued, popped;
        bit          stable_bad, overrun_bad, addr_bad, hold;
        logic [63:0] pdata, want;
        logic        plast;
        beats = 0; done_cyc = -1; first_v = -1; beat0 = '0;
        issued = 0; popped = 0; stable_bad = 0; overrun_bad = 0; addr_bad = 0;
        hold = 0; pdata = '0; plast = 1'b0;
        cfg_signed = sgn; start = 1'b1; tready = 1'b1;
        step();
        start = 1'b0; cfg_signed = ~sgn;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            start  = (cyc == extra_start) || (start_on_done && done);
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 1) chk("busy_rise", busy, 1);
            if (hold && (tvalid !== 1'b1 || tdata !== pdata || tlast !== plast)) stable_bad = 1;
            if (ena) begin
                if (addra !== 8'(2 * issued) || addrb !== 8'(2 * issued + 1) || enb !== 1'b1)
                    addr_bad = 1;
                issued++;
                if (issued - popped > DEPTH1) overrun_bad = 1;
            end
            if (wea || web) addr_bad = 1;
            if (tvalid && first_v < 0) first_v = cyc;
            if (tvalid && tready) begin
                if (beats < 128) begin
                    want = {exp_lane(mem1[2*beats+1], sgn), exp_lane(mem1[2*beats], sgn)};
                    chk("beat_data", tdata, want);
                    chk("beat_last", tlast, (beats == 127));
                end else begin
                    chk("extra_beat", beats, 127);
                end
                if (beats == 0) beat0 = tdata;
                beats++;
                popped++;
            end
            hold  = tvalid && !tready;
            pdata = tdata;
            plast = tlast;
            if (done) begin
                done_cyc = cyc;
                chk("busy_fall", busy, 0);
                step();
                break;
            end
            step();
        end
        start = 1'b0;
        tready = 1'b1;
        chk("done_seen", (done_cyc >= 0), 1);
        chk("tdata_stable", stable_bad, 0);
        chk("credit_ok", overrun_bad, 0);
        chk("addr_seq", addr_bad, 0);
        chk("reads_issued", issued, 128);
        chk("beat_count", beats, 128);
    endtask

    initial begin : main
        int          beats, done_cyc, first_v;
        logic [63:0] beat0;
        bit          bad;

        for (int i = 0; i < 256; i++) mem1[i] = 23'(i);
        mem2[0] = 23'h000005; mem2[1] = 23'h400001;
        mem2[2] = 23'h00000A; mem2[3] = 23'h7FFFFF;

        // Reset while idle.
        #12;
        chk("reset_idle", {busy, done, tvalid, tlast, ena, enb, wea, web, addra, addrb, tdata}, '0);
        chk("reset_idle2", {busy2, done2, tvalid2, tlast2, ena2, addra2, addrb2, tdata2}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Ordered stream with tready=1, start pulsed mid-run and on done.
        run_stream(0, 0, 20, 1, beats, done_cyc, first_v, beat0);
        chk("first_valid_cycle", first_v, 3);
        chk("done_cycle", done_cyc, 131);
        chk("beat0", beat0, 64'h00000001_00000000);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy || done || ena || tvalid) bad = 1;
            step();
        end
        chk("start_ignored", bad, 0);

        // Sign extension versus zero padding of the same coefficient.
        mem1[0] = 23'h400000;
        run_stream(0, 1, 0, 0, beats, done_cyc, first_v, beat0);
        chk("signed_lane0", beat0[31:0], 32'hFFC00000);
        run_stream(0, 0, 0, 0, beats, done_cyc, first_v, beat0);
        chk("unsigned_lane0", beat0[31:0], 32'h00400000);

        // Random data and 50% tready.
        for (int i = 0; i < 256; i++) mem1[i] = 23'($urandom);
        run_stream(1, 1, 0, 0, beats, done_cyc, first_v, beat0);

        // Reset in the middle of a stream.
        for (int i = 0; i < 256; i++) mem1[i] = 23'(i);
        cfg_signed = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        chk("mid_tvalid", tvalid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_mid", {busy, done, tvalid, tlast, ena, enb, wea, web, addra, addrb, tdata}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        run_stream(0, 0, 0, 0, beats, done_cyc, first_v, beat0);
        chk("post_reset_first_valid", first_v, 3);
        chk("post_reset_beat0", beat0, 64'h00000001_00000000);

        // RD_LAT=2, N_COEF=4.
        cfg_signed2 = 1'b1; start2 = 1'b1;
        step();
        start2 = 1'b0; cfg_signed2 = 1'b0;
        bad = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (tvalid2 !== (cyc == 4 || cyc == 5)) bad = 1;
            if (tlast2 !== (cyc == 5)) bad = 1;
            if (done2 !== (cyc == 6)) bad = 1;
            if (busy2 !== (cyc >= 1 && cyc <= 5)) bad = 1;
            if (cyc == 4) chk("lat2_beat0", tdata2, 64'hFFC00001_00000005);
            if (cyc == 5) chk("lat2_beat1", tdata2, 64'hFFFFFFFF_0000000A);
            if (cyc == 6) chk("lat2_done", done2, 1);
            step();
        end
        chk("lat2_timing", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
